// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates, packed colour and timing lock from a packed VGA bus.
//   clk          pixel clock
//   resetN       asynchronous active-low reset
//   iVGA         {clock, blankN, sync, VS, HS, R[7:0], G[7:0], B[7:0]}
//   RGBOut       {B[7:5], G[7:5], R[7:6]}, aligned with PixelX/PixelY/pixelValid
//   PixelX/Y     column / active line of the pixel presented on RGBOut
//   pixelValid   registered blankN
//   startOfFrame one-cycle pulse per VS falling edge
//   locked       high while the measured timing is trusted
//   hPeriod      clocks between the last two HS rising edges
//   vPeriod      HS rising edges between the last two VS falling edges
//   timingError  one-cycle pulse when locked timing is violated
//   errorCount   saturating count of timingError pulses
module vga_sync_decoder #(
   parameter int H_PERIOD    = 833,
   parameter int V_PERIOD    = 521,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic [28:0] iVGA,
   output logic [7:0]  RGBOut,
   output logic [10:0] PixelX,
   output logic [10:0] PixelY,
   output logic        pixelValid,
   output logic        startOfFrame,
   output logic        locked,
   output logic [10:0] hPeriod,
   output logic [10:0] vPeriod,
   output logic        timingError,
   output logic [7:0]  errorCount
);
   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
   localparam logic [10:0] CNT_MAX = 11'h7ff;
   localparam logic [10:0] H_EXP   = 11'(H_PERIOD);
   localparam logic [10:0] V_EXP   = 11'(V_PERIOD);
   localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);
   logic        hs1, vs1, bl1, hs2, vs2, bl2;
   logic [7:0]  rgb1;
   logic [10:0] h_cnt, v_cnt, x_cnt, y_cnt, h_meas, v_meas;
   logic        hs_rise, vs_fall, bl_fall, h_bad_now, v_bad_now, wd;
   state_t      state, state_n;
   logic [3:0]  match_cnt, match_n;
   logic        h_bad, h_bad_n, err;
   logic        unused_bits;
   // Pixel clock, composite sync and the colour LSBs carry nothing the sink needs.
   assign unused_bits = ^{iVGA[28], iVGA[26], iVGA[21:16], iVGA[12:8], iVGA[4:0]};
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         hs1  <= 1'b1;
         vs1  <= 1'b1;
         bl1  <= 1'b0;
         rgb1 <= '0;
         hs2  <= 1'b1;
         vs2  <= 1'b1;
         bl2  <= 1'b0;
      end else begin
         hs1  <= iVGA[24];
         vs1  <= iVGA[25];
         bl1  <= iVGA[27];
         rgb1 <= {iVGA[7:5], iVGA[15:13], iVGA[23:22]};
         hs2  <= hs1;
         vs2  <= vs1;
         bl2  <= bl1;
      end
   assign hs_rise = hs1 & ~hs2;
   assign vs_fall = ~vs1 & vs2;
   assign bl_fall = ~bl1 & bl2;
   // Period being closed by this edge: the counter has not yet counted the current clock / line.
   assign h_meas    = (h_cnt == CNT_MAX) ? h_cnt : h_cnt + 11'd1;
   assign v_meas    = (hs_rise && v_cnt != CNT_MAX) ? v_cnt + 11'd1 : v_cnt;
   assign h_bad_now = hs_rise && (h_meas != H_EXP);
   assign v_bad_now = v_meas != V_EXP;
   assign wd        = h_cnt == CNT_MAX;
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         h_cnt   <= '0;
         v_cnt   <= '0;
         x_cnt   <= '0;
         y_cnt   <= '0;
         hPeriod <= '0;
         vPeriod <= '0;
      end else begin
         h_cnt   <= hs_rise ? '0 : wd ? h_cnt : h_cnt + 11'd1;
         hPeriod <= hs_rise ? h_meas : hPeriod;
         v_cnt   <= vs_fall ? '0 : v_meas;
         vPeriod <= vs_fall ? v_meas : vPeriod;
         x_cnt   <= !bl1 ? '0 : (x_cnt == CNT_MAX) ? x_cnt : x_cnt + 11'd1;
         y_cnt   <= vs_fall ? '0 : (bl_fall && y_cnt != CNT_MAX) ? y_cnt + 11'd1 : y_cnt;
      end
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         state     <= SEARCH;
         match_cnt <= '0;
         h_bad     <= 1'b0;
      end else begin
         state     <= state_n;
         match_cnt <= match_n;
         h_bad     <= h_bad_n;
      end
   // The H check is folded into the V decision so a coincident bad line still spoils the frame,
   // and both checks share a single error pulse.
   always_comb begin
      state_n = state;
      match_n = match_cnt;
      h_bad_n = h_bad;
      err     = 1'b0;
      case (state)
         SEARCH:
            if (vs_fall) begin
               state_n = MEASURE;
               match_n = '0;
               h_bad_n = 1'b0;
            end
         MEASURE: begin
            if (h_bad_now)
               h_bad_n = 1'b1;
            if (vs_fall) begin
               match_n = (!h_bad && !h_bad_now && !v_bad_now) ? match_cnt + 4'd1 : '0;
               h_bad_n = 1'b0;
               state_n = (match_n == LOCK_N) ? LOCKED : MEASURE;
            end
         end
         LOCKED:
            if (h_bad_now || (vs_fall && v_bad_now)) begin
               err     = 1'b1;
               state_n = MEASURE;
               match_n = '0;
               h_bad_n = 1'b0;
            end
         default: state_n = SEARCH;
      endcase
      // A missing HS overrides everything: the stream is lost, not merely mistimed.
      if (wd) begin
         err     = state == LOCKED;
         state_n = SEARCH;
         match_n = '0;
         h_bad_n = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         RGBOut       <= '0;
         PixelX       <= '0;
         PixelY       <= '0;
         pixelValid   <= 1'b0;
         startOfFrame <= 1'b0;
         locked       <= 1'b0;
         timingError  <= 1'b0;
         errorCount   <= '0;
      end else begin
         RGBOut       <= rgb1;
         PixelX       <= bl1 ? x_cnt : '0;
         PixelY       <= y_cnt;
         pixelValid   <= bl1;
         startOfFrame <= vs_fall;
         locked       <= state_n == LOCKED;
         timingError  <= err;
         errorCount   <= (err && errorCount != 8'hff) ? errorCount + 8'd1 : errorCount;
      end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: scoreboard bench for vga_sync_decoder driven by a scaled-down VGA stream model.
module tb_vga_sync_decoder;
   localparam int HP  = 40;
   localparam int VP  = 12;
   localparam int AW  = 28;
   localparam int AH  = 8;
   localparam int HS0 = 30;
   localparam int HS1 = 34;
   localparam int VSL = 9;
   localparam int FR  = HP * VP;
   typedef struct {
      logic [7:0] rgb;
      int         x;
      int         y;
      bit         xok;
      bit         yok;
      int         cyc;
   } pix_t;
   logic        clk = 1'b0;
   logic        resetN;
   logic [28:0] iVGA;
   logic [7:0]  RGBOut;
   logic [10:0] PixelX, PixelY, hPeriod, vPeriod;
   logic        pixelValid, startOfFrame, locked, timingError;
   logic [7:0]  errorCount;
   pix_t        pq[$];
   int          sq[$];
   int          sof_log[$];
   int          lock_log[$];
   int          n_chk = 0, n_fail = 0, cyc = 0;
   int          gh = 0, gv = 0, vlines = VP;
   bit          del_req = 0, del_cur = 0, hold_hs = 0, rel_req = 0;
   bit          x_ok = 0, y_ok = 0, prev_vs = 1, prev_locked = 0;
   int          te_cnt = 0, te_hper = -1, te_locked = -1, te_ec = -1;
   int          a5_push = 0, a5_hits = 0;
   pix_t        me;
   vga_sync_decoder #(.H_PERIOD(HP), .V_PERIOD(VP), .LOCK_FRAMES(2)) dut (
      .clk(clk), .resetN(resetN), .iVGA(iVGA), .RGBOut(RGBOut), .PixelX(PixelX), .PixelY(PixelY),
      .pixelValid(pixelValid), .startOfFrame(startOfFrame), .locked(locked), .hPeriod(hPeriod),
      .vPeriod(vPeriod), .timingError(timingError), .errorCount(errorCount)
   );
   always #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end
   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   function automatic int last(input int q[$]);
      return (q.size() == 0) ? -1 : q[q.size() - 1];
   endfunction
   task automatic gen_cycle();
      logic hs, vs, bl;
      logic [7:0] p8;
      @(posedge clk);
      #1;
      if (rel_req) begin
         resetN  = 1'b1;
         rel_req = 0;
      end
      if (gh == 0) del_cur = 0;
      if (gh == HS0 && del_req) begin
         del_cur = 1;
         del_req = 0;
      end
      hs = hold_hs || del_cur || !(gh >= HS0 && gh < HS1);
      vs = gv != VSL;
      bl = (gh < AW) && (gv < AH);
      p8 = (gh == 5 && gv == 3) ? 8'hA5 : 8'(gh * 37 + gv * 11 + 1);
      if (!bl) p8 = 8'h00;
      iVGA = {1'b0, bl, 1'b0, vs, hs,
              {p8[1:0], p8[1:0], p8[1:0], p8[1:0]},
              {p8[4:2], p8[4:2], p8[4:3]},
              {p8[7:5], p8[7:5], p8[7:6]}};
      if (resetN) begin
         if (bl) begin
            pq.push_back('{p8, gh, gv, x_ok, y_ok, cyc + 2});
            if (p8 == 8'hA5) a5_push++;
         end
         if (!vs && prev_vs) sq.push_back(cyc + 2);
         if (!bl) x_ok = 1;
         if (!vs) y_ok = 1;
      end
      prev_vs = vs;
      gh++;
      if (gh == HP) begin
         gh = 0;
         if (!hold_hs) gv = (gv + 1 == vlines) ? 0 : gv + 1;
      end
   endtask
   task automatic run(input int n);
      repeat (n) gen_cycle();
   endtask
   task automatic chk_zero(input string p);
      chk({p, "_rgb"}, int'(RGBOut), 0);
      chk({p, "_x"}, int'(PixelX), 0);
      chk({p, "_y"}, int'(PixelY), 0);
      chk({p, "_valid"}, int'(pixelValid), 0);
      chk({p, "_sof"}, int'(startOfFrame), 0);
      chk({p, "_locked"}, int'(locked), 0);
      chk({p, "_hper"}, int'(hPeriod), 0);
      chk({p, "_vper"}, int'(vPeriod), 0);
      chk({p, "_terr"}, int'(timingError), 0);
      chk({p, "_ecnt"}, int'(errorCount), 0);
   endtask
   task automatic do_reset(input string p);
      #2;
      resetN = 1'b0;
      #1;
      chk_zero(p);
      pq.delete();
      sq.delete();
      sof_log.delete();
      lock_log.delete();
      x_ok = 0;
      y_ok = 0;
   endtask
   initial forever begin
      @(negedge clk);
      if (pixelValid) begin
         if (pq.size() == 0) chk("pix_unexpected", 1, 0);
         else begin
            me = pq.pop_front();
            chk("pix_rgb", int'(RGBOut), int'(me.rgb));
            chk("pix_latency", cyc, me.cyc);
            if (me.xok) chk("pix_x", int'(PixelX), me.x);
            if (me.yok) chk("pix_y", int'(PixelY), me.y);
            if (me.rgb == 8'hA5 && RGBOut == 8'hA5) a5_hits++;
         end
      end
      if (startOfFrame) begin
         if (sq.size() == 0) chk("sof_unexpected", 1, 0);
         else chk("sof_latency", cyc, sq.pop_front());
         sof_log.push_back(cyc);
      end
      if (timingError) begin
         te_cnt++;
         te_hper   = int'(hPeriod);
         te_locked = int'(locked);
         te_ec     = int'(errorCount);
      end
      if (locked && !prev_locked) lock_log.push_back(cyc);
      prev_locked = locked;
   end
   initial begin
      resetN = 1'b0;
      iVGA   = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h0};
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      rel_req = 1;
      run(3 * FR);
      chk("clean_locked", int'(locked), 1);
      chk("clean_hper", int'(hPeriod), HP);
      chk("clean_vper", int'(vPeriod), VP);
      chk("clean_terr", te_cnt, 0);
      chk("clean_ecnt", int'(errorCount), 0);
      chk("clean_sofs", sof_log.size(), 3);
      chk("clean_locks", lock_log.size(), 1);
      chk("clean_lock_at_sof3", last(lock_log), last(sof_log));
      del_req = 1;
      run(FR);
      chk("delhs_terr", te_cnt, 1);
      chk("delhs_hper", te_hper, 2 * HP);
      chk("delhs_locked_at_err", te_locked, 0);
      chk("delhs_ecnt_at_err", te_ec, 1);
      chk("delhs_locked", int'(locked), 0);
      chk("delhs_vper", int'(vPeriod), VP - 1);
      run(2 * FR);
      chk("delhs_relocked", int'(locked), 1);
      chk("delhs_locks", lock_log.size(), 2);
      chk("delhs_relock_at_sof", last(lock_log), last(sof_log));
      chk("delhs_terr_after", te_cnt, 1);
      chk("delhs_ecnt", int'(errorCount), 1);
      run(10 * HP);
      hold_hs = 1;
      run(53 * HP);
      hold_hs = 0;
      chk("hold_terr", te_cnt, 2);
      chk("hold_locked_at_err", te_locked, 0);
      chk("hold_ecnt_at_err", te_ec, 2);
      chk("hold_ecnt", int'(errorCount), 2);
      chk("hold_locked", int'(locked), 0);
      run(2 * HP + 2 * FR);
      chk("hold_still_unlocked", int'(locked), 0);
      run(FR);
      chk("hold_relocked", int'(locked), 1);
      chk("hold_locks", lock_log.size(), 3);
      chk("hold_relock_at_sof", last(lock_log), last(sof_log));
      chk("hold_hper", int'(hPeriod), HP);
      chk("hold_terr_after", te_cnt, 2);
      run(2 * HP + 10);
      chk("midrst_pre_locked", int'(locked), 1);
      do_reset("midrst");
      run(5);
      rel_req = 1;
      run(FR - 2 * HP - 15);
      chk("midrst_sofs_a", sof_log.size(), 1);
      run(FR);
      chk("midrst_unlocked", int'(locked), 0);
      run(FR);
      chk("midrst_relocked", int'(locked), 1);
      chk("midrst_locks", lock_log.size(), 1);
      chk("midrst_lock_at_sof3", last(lock_log), (sof_log.size() == 3) ? sof_log[2] : -2);
      chk("midrst_ecnt", int'(errorCount), 0);
      chk("midrst_terr", te_cnt, 2);
      do_reset("longrst");
      rel_req = 1;
      vlines  = 13;
      run(5 * 13 * HP);
      chk("long_vper", int'(vPeriod), 13);
      chk("long_hper", int'(hPeriod), HP);
      chk("long_locked", int'(locked), 0);
      chk("long_locks", lock_log.size(), 0);
      chk("long_ecnt", int'(errorCount), 0);
      chk("long_terr", te_cnt, 2);
      chk("long_sofs", sof_log.size(), 5);
      repeat (4) @(posedge clk);
      #1;
      chk("drain_pix", pq.size(), 0);
      chk("drain_sof", sq.size(), 0);
      chk("a5_seen", a5_hits, a5_push);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
